// File: rtl/irotary_encoder_if.sv
// Encoder pin / count-pulse bundle between the raw quadrature phases and the decoder.
// master drives the phases and observes the pulses; slave is the decoder side.
interface irotary_encoder_if;
  logic i_phase_a;
  logic i_phase_b;
  logic o_cnt;
  logic o_cnt_cw;
  logic o_cnt_err;

  modport master (
    output i_phase_a, i_phase_b,
    input  o_cnt, o_cnt_cw, o_cnt_err
  );

  modport slave (
    input  i_phase_a, i_phase_b,
    output o_cnt, o_cnt_cw, o_cnt_err
  );
endinterface

// File: rtl/irotary_encoder.sv
// Quadrature decoder: one count pulse per full detent, error pulse on 2-bit jumps.
// Define IROTARY_SYNC_EN to insert a 2-flop synchroniser on each phase input.
module irotary_encoder (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  irotary_encoder_if.slave       enc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CW1,
    ST_CW2,
    ST_CW3,
    ST_CCW1,
    ST_CCW2,
    ST_CCW3,
    ST_SYNC
  } state_e;

  state_e     state_q, state_d;
  logic       cnt_q, cnt_d;
  logic       cw_q, cw_d;
  logic       err_q, err_d;
  logic [1:0] phase;
  logic [1:0] code;

`ifdef IROTARY_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {enc.i_phase_b, enc.i_phase_a};
      sync2_q <= sync1_q;
    end
  end

  assign phase = sync2_q;
`else
  assign phase = {enc.i_phase_b, enc.i_phase_a};
`endif

  // Phase code each tracking state expects to see while resting in it.
  always_comb begin
    code = 2'b00;
    case (state_q)
      ST_CW1, ST_CCW3: code = 2'b01;
      ST_CW2, ST_CCW2: code = 2'b11;
      ST_CW3, ST_CCW1: code = 2'b10;
      default:         code = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 1'b0;
    cw_d    = cw_q;
    err_d   = 1'b0;
    if (state_q == ST_SYNC) begin
      if (phase == 2'b00)
        state_d = ST_IDLE;
    end else if (phase != code) begin
      if ((phase ^ code) == 2'b11) begin
        err_d   = 1'b1;
        state_d = (phase == 2'b00) ? ST_IDLE : ST_SYNC;
      end else begin
        // Single-bit change: the new code identifies forward vs. backward step.
        case (state_q)
          ST_IDLE: state_d = (phase == 2'b01) ? ST_CW1  : ST_CCW1;
          ST_CW1:  state_d = (phase == 2'b11) ? ST_CW2  : ST_IDLE;
          ST_CW2:  state_d = (phase == 2'b10) ? ST_CW3  : ST_CW1;
          ST_CW3: begin
            if (phase == 2'b00) begin
              state_d = ST_IDLE;
              cnt_d   = 1'b1;
              cw_d    = 1'b1;
            end else begin
              state_d = ST_CW2;
            end
          end
          ST_CCW1: state_d = (phase == 2'b11) ? ST_CCW2 : ST_IDLE;
          ST_CCW2: state_d = (phase == 2'b01) ? ST_CCW3 : ST_CCW1;
          ST_CCW3: begin
            if (phase == 2'b00) begin
              state_d = ST_IDLE;
              cnt_d   = 1'b1;
              cw_d    = 1'b0;
            end else begin
              state_d = ST_CCW2;
            end
          end
          default: state_d = ST_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_SYNC;
      cnt_q   <= 1'b0;
      cw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
      err_q   <= err_d;
    end
  end

  assign enc.o_cnt     = cnt_q;
  assign enc.o_cnt_cw  = cw_q;
  assign enc.o_cnt_err = err_q;

endmodule

// File: tb/tb_irotary_encoder.sv
// Directed vector bench for irotary_encoder (default build, phases sampled directly).
module tb_irotary_encoder;

  logic i_clk;
  logic i_rst_n;
  irotary_encoder_if enc ();

  irotary_encoder dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .enc     (enc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] p;
    logic       cnt;
    logic       cw;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] ucnt = 2'd0;

  // External up/down counter fed by the pulses.
  always @(posedge i_clk)
    if (enc.o_cnt) ucnt <= enc.o_cnt_cw ? ucnt + 2'd1 : ucnt - 2'd1;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] p, input logic c, input logic cw, input logic e);
    vec_t v;
    v.p = p; v.cnt = c; v.cw = cw; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [1:0] p, input logic c, input logic cw, input logic e,
                      input string tag);
    @(negedge i_clk);
    enc.i_phase_b = p[1];
    enc.i_phase_a = p[0];
    @(posedge i_clk);
    #1;
    check({tag, ".cnt"}, {1'b0, enc.o_cnt}, {1'b0, c});
    check({tag, ".cw"},  {1'b0, enc.o_cnt_cw}, {1'b0, cw});
    check({tag, ".err"}, {1'b0, enc.o_cnt_err}, {1'b0, e});
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].p, vecs[i].cnt, vecs[i].cw, vecs[i].err, $sformatf("%s[%0d]", tag, i));
    vecs.delete();
  endtask

  task automatic held_cycle(input logic cw_dir, input logic cw_before, input int n);
    logic [1:0] seq[4];
    if (cw_dir) begin
      seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
    end else begin
      seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    end
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 11; r++)
        step(seq[k], (k == 3 && r == 0), (n == 0 && k < 3) ? cw_before : cw_dir, 1'b0,
             $sformatf("held%0d_%0d_%0d_%0d", cw_dir, n, k, r));
  endtask

  initial begin
    enc.i_phase_a = 1'b0;
    enc.i_phase_b = 1'b0;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst.cnt", {1'b0, enc.o_cnt}, 2'd0);
    check("rst.cw",  {1'b0, enc.o_cnt_cw}, 2'd0);
    check("rst.err", {1'b0, enc.o_cnt_err}, 2'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Three fast CW detents from SYNC->IDLE
    add(2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      add(2'b01, 0, i > 0, 0);
      add(2'b11, 0, i > 0, 0);
      add(2'b10, 0, i > 0, 0);
      add(2'b00, 1, 1, 0);
    end
    add(2'b00, 0, 1, 0);
    run_vectors("cw");
    check("ucnt_cw", ucnt, 2'd3);

    for (int i = 0; i < 3; i++) begin
      add(2'b10, 0, i == 0, 0);
      add(2'b11, 0, i == 0, 0);
      add(2'b01, 0, i == 0, 0);
      add(2'b00, 1, 0, 0);
    end
    add(2'b00, 0, 0, 0);
    run_vectors("ccw");
    check("ucnt_ccw", ucnt, 2'd0);

    for (int n = 0; n < 3; n++) held_cycle(1'b1, 1'b0, n);
    step(2'b00, 0, 1, 0, "held_cw_tail");
    check("ucnt_held_cw", ucnt, 2'd3);
    for (int n = 0; n < 3; n++) held_cycle(1'b0, 1'b1, n);
    step(2'b00, 0, 0, 0, "held_ccw_tail");
    check("ucnt_held_ccw", ucnt, 2'd0);

    // Separate half-steps never count
    for (int i = 0; i < 3; i++) begin
      add(2'b01, 0, 0, 0); add(2'b00, 0, 0, 0);
      add(2'b10, 0, 0, 0); add(2'b00, 0, 0, 0);
    end
    // One CW detent sets cw=1 so glitches can be seen leaving it alone
    add(2'b01, 0, 0, 0); add(2'b11, 0, 0, 0); add(2'b10, 0, 0, 0); add(2'b00, 1, 1, 0);
    add(2'b00, 0, 1, 0); add(2'b11, 0, 1, 1); add(2'b00, 0, 1, 0);
    add(2'b00, 0, 1, 0); add(2'b10, 0, 1, 0); add(2'b11, 0, 1, 0); add(2'b00, 0, 1, 1);
    add(2'b00, 0, 1, 0); add(2'b10, 0, 1, 0); add(2'b11, 0, 1, 0); add(2'b10, 0, 1, 0);
    add(2'b00, 0, 1, 0);
    add(2'b00, 0, 1, 0); add(2'b01, 0, 1, 0); add(2'b11, 0, 1, 0); add(2'b01, 0, 1, 0);
    add(2'b00, 0, 1, 0);
    // Illegal jump from CW1 to 10 parks in SYNC until 00
    add(2'b01, 0, 1, 0); add(2'b10, 0, 1, 1); add(2'b11, 0, 1, 0); add(2'b00, 0, 1, 0);
    run_vectors("glitch");
    check("ucnt_glitch", ucnt, 2'd1);

    // Reset mid-sequence, resume in SYNC
    step(2'b01, 0, 1, 0, "mid0");
    step(2'b11, 0, 1, 0, "mid1");
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midrst.cnt", {1'b0, enc.o_cnt}, 2'd0);
    check("midrst.cw",  {1'b0, enc.o_cnt_cw}, 2'd0);
    check("midrst.err", {1'b0, enc.o_cnt_err}, 2'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    add(2'b11, 0, 0, 0); add(2'b10, 0, 0, 0); add(2'b00, 0, 0, 0);
    add(2'b01, 0, 0, 0); add(2'b11, 0, 0, 0); add(2'b10, 0, 0, 0); add(2'b00, 1, 1, 0);
    add(2'b00, 0, 1, 0);
    run_vectors("post_rst");
    check("ucnt_post_rst", ucnt, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
